// File: rtl/segment_led_decoder.sv
`default_nettype none
// ============================================================================
// Module  : segment_led_decoder
// Purpose : Decodes settled two-digit seven-segment buses back to a count and flags illegal patterns.
// Revision: 1.0
// ============================================================================
module segment_led_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [8:0] segment_led_1,
  input  logic [8:0] segment_led_2,
  output logic [7:0] count_out,
  output logic       count_valid,
  output logic       count_upd,
  output logic       err,
  output logic [2:0] err_code,
  output logic [7:0] err_cnt
);

  localparam logic [7:0] C_STABLE = 8'(STABLE_CYCLES);

  typedef enum logic [2:0] {
    S_BLANK  = 3'd0,
    S_SETTLE = 3'd1,
    S_CHECK  = 3'd2,
    S_TRACK  = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [17:0] r_seg_q;
  logic [7:0]  r_stab_cnt;
  logic [7:0]  r_count_out;
  logic        r_count_valid;
  logic        r_count_upd;
  logic        r_err;
  logic [2:0]  r_err_code;
  logic [7:0]  r_err_cnt;

  logic [7:0]  w_count_out_nxt;
  logic        w_count_valid_nxt;
  logic        w_count_upd_nxt;
  logic        w_err_nxt;
  logic [2:0]  w_err_code_nxt;
  logic [7:0]  w_err_cnt_nxt;

  logic [17:0] w_seg_in;
  logic [4:0]  w_ones;
  logic [4:0]  w_tens;
  logic [1:0]  w_dp;
  logic [1:0]  w_blank;
  logic [1:0]  w_hund;
  logic [8:0]  w_value;
  logic [2:0]  w_code;
  logic        w_both_blank;

  // Returns {legal, digit}.
  function automatic logic [4:0] f_seg_decode(input logic [6:0] seg);
    logic [4:0] d;
    case (seg)
      7'h3F:   d = {1'b1, 4'd0};
      7'h06:   d = {1'b1, 4'd1};
      7'h5B:   d = {1'b1, 4'd2};
      7'h4F:   d = {1'b1, 4'd3};
      7'h66:   d = {1'b1, 4'd4};
      7'h6D:   d = {1'b1, 4'd5};
      7'h7D:   d = {1'b1, 4'd6};
      7'h07:   d = {1'b1, 4'd7};
      7'h7F:   d = {1'b1, 4'd8};
      7'h6F:   d = {1'b1, 4'd9};
      default: d = 5'd0;
    endcase
    return d;
  endfunction

  assign w_seg_in     = {segment_led_1, segment_led_2};
  assign w_ones       = f_seg_decode(r_seg_q[6:0]);
  assign w_tens       = f_seg_decode(r_seg_q[15:9]);
  assign w_dp         = {r_seg_q[16], r_seg_q[7]};
  assign w_blank      = {r_seg_q[17], r_seg_q[8]};
  assign w_both_blank = &w_blank;

  always_comb begin
    w_hund = 2'd0;
    case (w_dp)
      2'b01:   w_hund = 2'd1;
      2'b11:   w_hund = 2'd2;
      default: w_hund = 2'd0;
    endcase
  end

  assign w_value = ({7'd0, w_hund} * 9'd100) + ({5'd0, w_tens[3:0]} * 9'd10)
                 + {5'd0, w_ones[3:0]};

  // Lowest-numbered cause wins; zero means the pattern is legal.
  always_comb begin
    w_code = 3'd0;
    if (!w_ones[4])                 w_code = 3'd1;
    else if (!w_tens[4])            w_code = 3'd2;
    else if (w_dp == 2'b10)         w_code = 3'd3;
    else if (w_value > 9'd255)      w_code = 3'd4;
    else if (w_blank[0] ^ w_blank[1]) w_code = 3'd5;
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_count_out_nxt   = r_count_out;
    w_count_valid_nxt = r_count_valid;
    w_count_upd_nxt   = 1'b0;
    w_err_nxt         = 1'b0;
    w_err_code_nxt    = r_err_code;
    w_err_cnt_nxt     = r_err_cnt;
    if (w_both_blank) begin
      w_state_nxt       = S_BLANK;
      w_count_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_BLANK: begin
          w_count_valid_nxt = 1'b0;
          w_state_nxt       = S_SETTLE;
        end
        S_SETTLE: begin
          // Results are registered on the edge entering CHECK so pulses line up with the new data.
          if (r_stab_cnt == C_STABLE) begin
            w_state_nxt = S_CHECK;
            if (w_code == 3'd0) begin
              w_count_out_nxt   = w_value[7:0];
              w_count_valid_nxt = 1'b1;
              w_count_upd_nxt   = !r_count_valid || (w_value[7:0] != r_count_out);
            end else begin
              w_err_nxt         = 1'b1;
              w_err_code_nxt    = w_code;
              w_count_valid_nxt = 1'b0;
              if (r_err_cnt != 8'hFF) w_err_cnt_nxt = r_err_cnt + 8'd1;
            end
          end
        end
        S_CHECK: w_state_nxt = r_count_valid ? S_TRACK : S_FAULT;
        S_TRACK, S_FAULT: begin
          if (r_stab_cnt != C_STABLE) w_state_nxt = S_SETTLE;
        end
        default: w_state_nxt = S_BLANK;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= S_BLANK;
      r_seg_q       <= 18'd0;
      r_stab_cnt    <= 8'd0;
      r_count_out   <= 8'd0;
      r_count_valid <= 1'b0;
      r_count_upd   <= 1'b0;
      r_err         <= 1'b0;
      r_err_code    <= 3'd0;
      r_err_cnt     <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_seg_q       <= w_seg_in;
      if (w_seg_in != r_seg_q)       r_stab_cnt <= 8'd0;
      else if (r_stab_cnt < C_STABLE) r_stab_cnt <= r_stab_cnt + 8'd1;
      r_count_out   <= w_count_out_nxt;
      r_count_valid <= w_count_valid_nxt;
      r_count_upd   <= w_count_upd_nxt;
      r_err         <= w_err_nxt;
      r_err_code    <= w_err_code_nxt;
      r_err_cnt     <= w_err_cnt_nxt;
    end
  end

  assign count_out   = r_count_out;
  assign count_valid = r_count_valid;
  assign count_upd   = r_count_upd;
  assign err         = r_err;
  assign err_code    = r_err_code;
  assign err_cnt     = r_err_cnt;

endmodule
`default_nettype wire
